// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchronised serial input, mid-bit sampling, REQ/ACK word delivery.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (default build: no parity, PARITY_ERR tied 0).
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 RCV,
    input  logic                 RCV_ACK,
    output logic                 RCV_REQ,
    output logic [DATA_BITS-1:0] RCV_DATA,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_reg, state_next;
    logic                 rcv_meta_reg, rs_reg;
    logic [TW-1:0]        timer_reg;
    logic [IW-1:0]        bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 req_reg, frame_err_reg, overrun_reg;
    logic                 tick, last_bit, stop_tick, deliver;

    assign tick      = (timer_reg == '0);
    assign last_bit  = (bit_idx_reg == IW'(DATA_BITS - 1));
    assign stop_tick = (state_reg == S_STOP) && tick;
    // A word is only handed over when the consumer is fully idle; anything else counts as dropped.
    assign deliver   = stop_tick && !req_reg && !RCV_ACK;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rcv_meta_reg <= 1'b1;
            rs_reg       <= 1'b1;
        end else begin
            rcv_meta_reg <= RCV;
            rs_reg       <= rcv_meta_reg;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (!rs_reg) state_next = S_START;
            end
            S_START: begin
                if (tick) state_next = rs_reg ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) state_next = rs_reg ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rs_reg) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Timer is held at the half-bit load while idle so the start-bit check lands mid-bit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            if (state_reg == S_IDLE) begin
                timer_reg <= HALF_LOAD;
            end else if (tick) begin
                timer_reg <= FULL_LOAD;
            end else begin
                timer_reg <= timer_reg - 1'b1;
            end

            if (state_reg == S_START) begin
                bit_idx_reg <= '0;
            end else if (state_reg == S_DATA && tick) begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
            end

            if (state_reg == S_DATA && tick) begin
                shift_reg <= {rs_reg, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            req_reg       <= 1'b0;
            data_reg      <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (req_reg && RCV_ACK) begin
                req_reg <= 1'b0;
            end
            if (deliver) begin
                req_reg       <= 1'b1;
                data_reg      <= shift_reg;
                frame_err_reg <= ~rs_reg;
            end else if (stop_tick) begin
                overrun_reg <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_reg, parity_err_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            if (state_reg == S_PARITY && tick) begin
                par_bad_reg <= rs_reg ^ (^shift_reg) ^ PARITY_ODD;
            end
            if (deliver) begin
                parity_err_reg <= par_bad_reg;
            end
        end
    end

    assign PARITY_ERR = parity_err_reg;
`else
    // No parity bit on the line in this build; the parameter only keeps the interface uniform.
    assign PARITY_ERR = PARITY_ODD & 1'b0;
`endif

    assign RCV_REQ   = req_reg;
    assign RCV_DATA  = data_reg;
    assign FRAME_ERR = frame_err_reg;
    assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are serialised bit by bit, expected words queued at send time.
module tb_uart_rx_param;
    localparam int CPB  = 10;
    localparam int DW   = 8;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          RCV;
    logic          RCV_ACK;
    logic          RCV_REQ;
    logic [DW-1:0] RCV_DATA;
    logic          FRAME_ERR;
    logic          PARITY_ERR;
    logic          OVERRUN;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;

    exp_t sb_q[$];

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DW),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .RCV       (RCV),
        .RCV_ACK   (RCV_ACK),
        .RCV_REQ   (RCV_REQ),
        .RCV_DATA  (RCV_DATA),
        .FRAME_ERR (FRAME_ERR),
        .PARITY_ERR(PARITY_ERR),
        .OVERRUN   (OVERRUN)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},  32'(RCV_REQ),    32'd0);
        check({tag, "_data"}, 32'(RCV_DATA),   32'd0);
        check({tag, "_ferr"}, 32'(FRAME_ERR),  32'd0);
        check({tag, "_perr"}, 32'(PARITY_ERR), 32'd0);
        check({tag, "_ovr"},  32'(OVERRUN),    32'd0);
    endtask

    // Drives one frame starting at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [DW-1:0] data, input logic stop, input bit par_flip,
                              input bit push, input bit lat_chk);
        exp_t e;
        if (push) begin
            e.data = data;
            e.ferr = ~stop;
            e.perr = par_flip & PAR_EN;
            sb_q.push_back(e);
        end
        RCV = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            RCV = data[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        RCV = (^data) ^ PODD ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        RCV = stop;
        for (int i = 0; i < CPB; i++) begin
            if (lat_chk && i == CPB / 2 + 2) check("req_before_latency", 32'(RCV_REQ), 32'd0);
            if (lat_chk && i == CPB / 2 + 3) check("req_at_latency", 32'(RCV_REQ), 32'd1);
            @(negedge clk);
        end
    endtask

    task automatic receive_word(input int ack_delay);
        int   waited = 0;
        exp_t e;
        while (!RCV_REQ && waited < 3 * CPB * (DW + 3)) begin
            @(negedge clk);
            waited++;
        end
        if (!RCV_REQ) begin
            check("req_timeout", 32'(RCV_REQ), 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check("unexpected_word", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check("data",       32'(RCV_DATA),   32'(e.data));
        check("frame_err",  32'(FRAME_ERR),  32'(e.ferr));
        check("parity_err", 32'(PARITY_ERR), 32'(e.perr));
        repeat (ack_delay) @(negedge clk);
        check("req_held",  32'(RCV_REQ),  32'd1);
        check("data_held", 32'(RCV_DATA), 32'(e.data));
        RCV_ACK = 1'b1;
        @(negedge clk);
        check("req_drop", 32'(RCV_REQ), 32'd0);
        RCV_ACK = 1'b0;
        @(negedge clk);
        $display("rx word 0x%02h ferr=%0b perr=%0b ovr=%0b", e.data, e.ferr, e.perr, OVERRUN);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr     = 1'b1;
        RCV     = 1'b1;
        RCV_ACK = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        clr = 1'b0;
        repeat (5) @(negedge clk);

        // Plain frame with exact REQ latency and delayed ACK.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        receive_word(5);
        check("t1_ovr", 32'(OVERRUN), 32'd0);

        // Short low glitch is rejected, following frame still lands.
        RCV = 1'b0;
        repeat (3) @(negedge clk);
        RCV = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_req", 32'(RCV_REQ), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        receive_word(3);

        // Missing stop bit then held-low line: one flagged word, no phantom frame.
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        receive_word(5);
        repeat (25) @(negedge clk);
        check("break_no_req", 32'(RCV_REQ), 32'd0);
        RCV = 1'b1;
        repeat (CPB * (DW + 4)) @(negedge clk);
        check("after_break_no_req", 32'(RCV_REQ), 32'd0);
        check("after_break_queue", 32'(sb_q.size()), 32'd0);

        // Second frame while the first is unacknowledged is dropped and flagged.
        check("t4_ovr_before", 32'(OVERRUN), 32'd0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_data_kept", 32'(RCV_DATA), 32'h11);
        check("t4_ovr_set", 32'(OVERRUN), 32'd1);
        receive_word(2);
        check("t4_ovr_sticky", 32'(OVERRUN), 32'd1);
        repeat (2 * CPB) @(negedge clk);
        check("t4_ovr_still", 32'(OVERRUN), 32'd1);

        // Reset pulse in the middle of data bit 4 discards the partial word.
        fork
            send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                repeat (5 * CPB + 5) @(negedge clk);
                clr = 1'b1;
                @(negedge clk);
                check_all_zero("mid_clr");
                @(negedge clk);
                clr = 1'b0;
            end
        join
        repeat (2 * CPB) @(negedge clk);
        check("post_clr_no_req", 32'(RCV_REQ), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
        receive_word(4);
        check("post_clr_ovr", 32'(OVERRUN), 32'd0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        receive_word(3);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        receive_word(3);
`endif

        for (int k = 0; k < 3; k++) begin
            send_frame(DW'($urandom_range(0, (1 << DW) - 1)), 1'b1, 1'b0, 1'b1, 1'b1);
            receive_word(int'($urandom_range(1, 6)));
        end

        check("queue_drained", 32'(sb_q.size()), 32'd0);
        check("final_ovr", 32'(OVERRUN), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
